// File: rtl/acp_mem_responder.sv
// AXI3 slave for the Xillybus 64-bit ACP master port, backed by a byte-enabled on-chip RAM.
// Read and write channels run independently with one outstanding burst per direction.
module acp_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [63:0] RD_FILL    = 64'h0
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic [31:0] S_ACP_AWADDR,
  input  logic [3:0]  S_ACP_AWLEN,
  input  logic [2:0]  S_ACP_AWSIZE,
  input  logic [1:0]  S_ACP_AWBURST,
  input  logic [3:0]  S_ACP_AWCACHE,
  input  logic [2:0]  S_ACP_AWPROT,
  input  logic        S_ACP_AWVALID,
  output logic        S_ACP_AWREADY,
  input  logic [63:0] S_ACP_WDATA,
  input  logic [7:0]  S_ACP_WSTRB,
  input  logic        S_ACP_WLAST,
  input  logic        S_ACP_WVALID,
  output logic        S_ACP_WREADY,
  output logic [1:0]  S_ACP_BRESP,
  output logic        S_ACP_BVALID,
  input  logic        S_ACP_BREADY,
  input  logic [31:0] S_ACP_ARADDR,
  input  logic [3:0]  S_ACP_ARLEN,
  input  logic [2:0]  S_ACP_ARSIZE,
  input  logic [1:0]  S_ACP_ARBURST,
  input  logic [3:0]  S_ACP_ARCACHE,
  input  logic [2:0]  S_ACP_ARPROT,
  input  logic        S_ACP_ARVALID,
  output logic        S_ACP_ARREADY,
  output logic [63:0] S_ACP_RDATA,
  output logic [1:0]  S_ACP_RRESP,
  output logic        S_ACP_RLAST,
  output logic        S_ACP_RVALID,
  input  logic        S_ACP_RREADY
);

  localparam int unsigned IW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Only 64-bit beats in INCR or FIXED bursts are served.
  function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'd3) && !burst[1];
  endfunction

  logic [63:0] mem [DEPTH];

  // Address bits outside the word index and the cache/prot attributes carry no meaning here.
  logic unused_c;
  assign unused_c = ^{S_ACP_AWCACHE, S_ACP_AWPROT, S_ACP_ARCACHE, S_ACP_ARPROT,
                      S_ACP_AWADDR[31:IW+3], S_ACP_AWADDR[2:0],
                      S_ACP_ARADDR[31:IW+3], S_ACP_ARADDR[2:0]};

  // ---------------- write channel ----------------
  w_state_t        w_state, w_state_nxt;
  logic [IW-1:0]   w_idx, w_idx_nxt;
  logic [3:0]      w_len, w_len_nxt, w_beat, w_beat_nxt;
  logic            w_fixed, w_fixed_nxt, w_legal, w_legal_nxt, w_err, w_err_nxt;
  logic            aw_ready_q, aw_ready_nxt, w_ready_q, w_ready_nxt, b_valid_q, b_valid_nxt;
  logic [1:0]      b_resp_q, b_resp_nxt;
  logic [7:0]      mem_we_c;
  logic            w_last_c;

  assign S_ACP_AWREADY = aw_ready_q;
  assign S_ACP_WREADY  = w_ready_q;
  assign S_ACP_BVALID  = b_valid_q;
  assign S_ACP_BRESP   = b_resp_q;

  always_comb begin
    w_state_nxt  = w_state;
    w_idx_nxt    = w_idx;
    w_len_nxt    = w_len;
    w_beat_nxt   = w_beat;
    w_fixed_nxt  = w_fixed;
    w_legal_nxt  = w_legal;
    w_err_nxt    = w_err;
    aw_ready_nxt = aw_ready_q;
    w_ready_nxt  = w_ready_q;
    b_valid_nxt  = b_valid_q;
    b_resp_nxt   = b_resp_q;
    mem_we_c     = '0;
    w_last_c     = (w_beat == w_len);
    case (w_state)
      W_IDLE: begin
        if (S_ACP_AWVALID && aw_ready_q) begin
          w_idx_nxt    = S_ACP_AWADDR[IW+2:3];
          w_len_nxt    = S_ACP_AWLEN;
          w_beat_nxt   = '0;
          w_fixed_nxt  = (S_ACP_AWBURST == 2'b00);
          w_legal_nxt  = burst_ok(S_ACP_AWSIZE, S_ACP_AWBURST);
          w_err_nxt    = 1'b0;
          aw_ready_nxt = 1'b0;
          w_ready_nxt  = 1'b1;
          w_state_nxt  = W_DATA;
        end
      end
      W_DATA: begin
        if (S_ACP_WVALID && w_ready_q) begin
          if (w_legal) mem_we_c = S_ACP_WSTRB;
          if (S_ACP_WLAST != w_last_c) w_err_nxt = 1'b1;
          // Beat count, not WLAST, decides where the burst ends.
          if (w_last_c) begin
            w_ready_nxt = 1'b0;
            b_valid_nxt = 1'b1;
            b_resp_nxt  = (!w_legal || w_err_nxt) ? RESP_SLVERR : RESP_OKAY;
            w_state_nxt = W_RESP;
          end else begin
            w_beat_nxt = w_beat + 4'd1;
            if (!w_fixed) w_idx_nxt = w_idx + IW'(1);
          end
        end
      end
      W_RESP: begin
        if (S_ACP_BREADY && b_valid_q) begin
          b_valid_nxt  = 1'b0;
          b_resp_nxt   = RESP_OKAY;
          aw_ready_nxt = 1'b1;
          w_state_nxt  = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      w_state    <= W_IDLE;
      w_idx      <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_fixed    <= 1'b0;
      w_legal    <= 1'b0;
      w_err      <= 1'b0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      w_state    <= w_state_nxt;
      w_idx      <= w_idx_nxt;
      w_len      <= w_len_nxt;
      w_beat     <= w_beat_nxt;
      w_fixed    <= w_fixed_nxt;
      w_legal    <= w_legal_nxt;
      w_err      <= w_err_nxt;
      aw_ready_q <= aw_ready_nxt;
      w_ready_q  <= w_ready_nxt;
      b_valid_q  <= b_valid_nxt;
      b_resp_q   <= b_resp_nxt;
    end
  end

  // RAM contents survive reset; a beat coinciding with reset is dropped.
  always_ff @(posedge bus_clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_we_c[i] && !bus_rst) mem[w_idx][8*i +: 8] <= S_ACP_WDATA[8*i +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t        r_state, r_state_nxt;
  logic [IW-1:0]   r_idx, r_idx_nxt;
  logic [3:0]      r_len, r_len_nxt, r_beat, r_beat_nxt;
  logic            r_fixed, r_fixed_nxt, r_legal, r_legal_nxt;
  logic            ar_ready_q, ar_ready_nxt, r_valid_q, r_valid_nxt, r_last_q, r_last_nxt;
  logic [1:0]      r_resp_q, r_resp_nxt;
  logic [63:0]     r_data_q;

  assign S_ACP_ARREADY = ar_ready_q;
  assign S_ACP_RVALID  = r_valid_q;
  assign S_ACP_RLAST   = r_last_q;
  assign S_ACP_RRESP   = r_resp_q;
  assign S_ACP_RDATA   = r_data_q;

  always_comb begin
    r_state_nxt  = r_state;
    r_idx_nxt    = r_idx;
    r_len_nxt    = r_len;
    r_beat_nxt   = r_beat;
    r_fixed_nxt  = r_fixed;
    r_legal_nxt  = r_legal;
    ar_ready_nxt = ar_ready_q;
    r_valid_nxt  = r_valid_q;
    r_last_nxt   = r_last_q;
    r_resp_nxt   = r_resp_q;
    case (r_state)
      R_IDLE: begin
        if (S_ACP_ARVALID && ar_ready_q) begin
          r_idx_nxt    = S_ACP_ARADDR[IW+2:3];
          r_len_nxt    = S_ACP_ARLEN;
          r_beat_nxt   = '0;
          r_fixed_nxt  = (S_ACP_ARBURST == 2'b00);
          r_legal_nxt  = burst_ok(S_ACP_ARSIZE, S_ACP_ARBURST);
          ar_ready_nxt = 1'b0;
          r_state_nxt  = R_FETCH;
        end
      end
      R_FETCH: begin
        r_valid_nxt = 1'b1;
        r_last_nxt  = (r_beat == r_len);
        r_resp_nxt  = r_legal ? RESP_OKAY : RESP_SLVERR;
        r_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (S_ACP_RREADY && r_valid_q) begin
          r_valid_nxt = 1'b0;
          r_last_nxt  = 1'b0;
          if (r_last_q) begin
            ar_ready_nxt = 1'b1;
            r_resp_nxt   = RESP_OKAY;
            r_state_nxt  = R_IDLE;
          end else begin
            r_beat_nxt  = r_beat + 4'd1;
            if (!r_fixed) r_idx_nxt = r_idx + IW'(1);
            r_state_nxt = R_FETCH;
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_state    <= R_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_fixed    <= 1'b0;
      r_legal    <= 1'b0;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      r_state    <= r_state_nxt;
      r_idx      <= r_idx_nxt;
      r_len      <= r_len_nxt;
      r_beat     <= r_beat_nxt;
      r_fixed    <= r_fixed_nxt;
      r_legal    <= r_legal_nxt;
      ar_ready_q <= ar_ready_nxt;
      r_valid_q  <= r_valid_nxt;
      r_last_q   <= r_last_nxt;
      r_resp_q   <= r_resp_nxt;
    end
  end

  // Synchronous RAM read doubles as the RDATA holding register (read-first vs. writes).
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_data_q <= '0;
    end else if (r_state == R_FETCH) begin
      r_data_q <= r_legal ? mem[r_idx] : RD_FILL;
    end
  end

endmodule

// File: tb/tb_acp_mem_responder.sv
// Directed self-checking bench for acp_mem_responder: bursts, strobes, backpressure,
// illegal bursts, index wrap and reset in the middle of a write burst.
module tb_acp_mem_responder;

  localparam int unsigned DL2  = 9;
  localparam logic [63:0] FILL = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awcache, arcache;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int n_tests = 0;
  int n_fail  = 0;
  int first_wait;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rresp_buf [16];
  logic        rlast_buf [16];
  logic [1:0]  wr_resp;

  always #5 clk = ~clk;

  acp_mem_responder #(.DEPTH_LOG2(DL2), .RD_FILL(FILL)) dut (
    .bus_clk(clk), .bus_rst(rst),
    .S_ACP_AWADDR(awaddr), .S_ACP_AWLEN(awlen), .S_ACP_AWSIZE(awsize), .S_ACP_AWBURST(awburst),
    .S_ACP_AWCACHE(awcache), .S_ACP_AWPROT(awprot), .S_ACP_AWVALID(awvalid), .S_ACP_AWREADY(awready),
    .S_ACP_WDATA(wdata), .S_ACP_WSTRB(wstrb), .S_ACP_WLAST(wlast), .S_ACP_WVALID(wvalid),
    .S_ACP_WREADY(wready), .S_ACP_BRESP(bresp), .S_ACP_BVALID(bvalid), .S_ACP_BREADY(bready),
    .S_ACP_ARADDR(araddr), .S_ACP_ARLEN(arlen), .S_ACP_ARSIZE(arsize), .S_ACP_ARBURST(arburst),
    .S_ACP_ARCACHE(arcache), .S_ACP_ARPROT(arprot), .S_ACP_ARVALID(arvalid), .S_ACP_ARREADY(arready),
    .S_ACP_RDATA(rdata), .S_ACP_RRESP(rresp), .S_ACP_RLAST(rlast), .S_ACP_RVALID(rvalid),
    .S_ACP_RREADY(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one write burst from wbuf; WLAST is asserted on beat last_beat.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] strb, input int last_beat);
    int n;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw_handshake", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wbuf[b]; wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      check("w_handshake", 64'(wready), 64'd1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("b_handshake", 64'(bvalid), 64'd1);
    wr_resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Reads one burst into rbuf; with stall set, each beat is held off one cycle first.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit stall);
    int n;
    logic [63:0] hold;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar_handshake", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      check("r_valid_seen", 64'(rvalid), 64'd1);
      if (b == 0) first_wait = n;
      if (stall) begin
        hold = rdata;
        @(negedge clk);
        check("rdata_hold", rdata, hold);
      end
      rready = 1'b1;
      rbuf[b] = rdata; rresp_buf[b] = rresp; rlast_buf[b] = rlast;
      @(negedge clk);
      rready = 1'b0;
    end
    check("r_done", 64'({rvalid, arready}), 64'b01);
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'h0102_0304_0506_0708 * 64'(i + 1) ^ 64'hF0F0_0000_0000_0F0F;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rdata",   rdata,        64'd0);

    // Aligned INCR write and readback
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
    axi_write(32'h100, 4'd3, 3'd3, 2'b01, 8'hFF, 3);
    check("incr_bresp", 64'(wr_resp), 64'd0);
    axi_read(32'h100, 4'd3, 3'd3, 2'b01, 1'b0);
    check("ar_to_rvalid", 64'(first_wait), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rbuf[i], wbuf[i]);
      check("incr_rlast", 64'(rlast_buf[i]), 64'(i == 3));
      check("incr_rresp", 64'(rresp_buf[i]), 64'd0);
    end

    // Byte strobes
    wbuf[0] = '1;
    axi_write(32'h0, 4'd0, 3'd3, 2'b01, 8'hFF, 0);
    wbuf[0] = '0;
    axi_write(32'h0, 4'd0, 3'd3, 2'b01, 8'h0F, 0);
    check("strb_bresp", 64'(wr_resp), 64'd0);
    axi_read(32'h0, 4'd0, 3'd3, 2'b01, 1'b0);
    check("strb_rdata", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // 16-beat read with RREADY backpressure
    for (int i = 0; i < 16; i++) wbuf[i] = pat(i);
    axi_write(32'h200, 4'd15, 3'd3, 2'b01, 8'hFF, 15);
    check("long_bresp", 64'(wr_resp), 64'd0);
    axi_read(32'h200, 4'd15, 3'd3, 2'b01, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("long_rdata", rbuf[i], pat(i));
      check("long_rlast", 64'(rlast_buf[i]), 64'(i == 15));
    end

    // Early WLAST: all four beats taken, sticky error reported
    for (int i = 0; i < 4; i++) wbuf[i] = pat(i + 20);
    axi_write(32'h300, 4'd3, 3'd3, 2'b01, 8'hFF, 1);
    check("early_wlast_bresp", 64'(wr_resp), 64'd2);
    axi_read(32'h318, 4'd0, 3'd3, 2'b01, 1'b0);
    check("early_wlast_beat3", rbuf[0], pat(23));

    // Illegal write burst type leaves RAM untouched
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hBAD0_BAD0_BAD0_BAD0;
    axi_write(32'h100, 4'd3, 3'd3, 2'b10, 8'hFF, 3);
    check("wrap_type_bresp", 64'(wr_resp), 64'd2);
    axi_read(32'h100, 4'd3, 3'd3, 2'b01, 1'b0);
    check("ill_w_word0", rbuf[0], 64'h1111_1111_1111_1111);
    check("ill_w_word3", rbuf[3], 64'h4444_4444_4444_4444);

    // Illegal read size returns fill with SLVERR
    axi_read(32'h100, 4'd1, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("ill_r_data", rbuf[i], FILL);
      check("ill_r_resp", 64'(rresp_buf[i]), 64'd2);
      check("ill_r_last", 64'(rlast_buf[i]), 64'(i == 1));
    end

    // INCR wraps from the last index to index 0
    wbuf[0] = 64'hA5A5_A5A5_A5A5_A5A5; wbuf[1] = 64'h5A5A_5A5A_5A5A_5A5A;
    axi_write(32'hFF8, 4'd1, 3'd3, 2'b01, 8'hFF, 1);
    check("wrap_bresp", 64'(wr_resp), 64'd0);
    axi_read(32'h0, 4'd0, 3'd3, 2'b01, 1'b0);
    check("wrap_word0", rbuf[0], 64'h5A5A_5A5A_5A5A_5A5A);
    axi_read(32'hFF8, 4'd1, 3'd3, 2'b01, 1'b0);
    check("wrap_rd0", rbuf[0], 64'hA5A5_A5A5_A5A5_A5A5);
    check("wrap_rd1", rbuf[1], 64'h5A5A_5A5A_5A5A_5A5A);

    // FIXED bursts stay on one word
    wbuf[0] = 64'h0000_0000_0000_00C1; wbuf[1] = 64'h0000_0000_0000_00C2;
    wbuf[2] = 64'h0000_0000_0000_00C3;
    axi_write(32'h400, 4'd2, 3'd3, 2'b00, 8'hFF, 2);
    check("fixed_bresp", 64'(wr_resp), 64'd0);
    axi_read(32'h400, 4'd1, 3'd3, 2'b00, 1'b0);
    check("fixed_rd0", rbuf[0], 64'h0000_0000_0000_00C3);
    check("fixed_rd1", rbuf[1], 64'h0000_0000_0000_00C3);

    // Reset during beat 2 of an 8-beat write
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h7000 + 64'(i);
    axi_write(32'h500, 4'd7, 3'd3, 2'b01, 8'hFF, 7);
    @(negedge clk);
    awaddr = 32'h500; awlen = 4'd7; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("rst_aw_handshake", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = 64'h9000 + 64'(b); wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      check("rst_w_handshake", 64'(wready), 64'd1);
      @(negedge clk);
    end
    wdata = 64'h9002; wvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0;
    check("midrst_awready", 64'(awready), 64'd1);
    check("midrst_arready", 64'(arready), 64'd1);
    check("midrst_wready",  64'(wready),  64'd0);
    check("midrst_bvalid",  64'(bvalid),  64'd0);
    axi_read(32'h500, 4'd7, 3'd3, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++)
      check("midrst_word", rbuf[i], (i < 2) ? 64'h9000 + 64'(i) : 64'h7000 + 64'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acp_mem_responder.md
Name: acp_mem_responder

Overview:
- AXI3 slave that answers the 64-bit ACP master port of the Xillybus core, backed by an internal byte-enabled RAM.
- Lets the core's DMA engine run against on-chip memory in simulation and board bring-up, with no PS/DDR in the loop.
- Read and write channels are independent, with one outstanding transaction per direction.

Parameters:
- DEPTH_LOG2, 9, RAM depth is 2**DEPTH_LOG2 words of 64 bits.
- RD_FILL, 64'h0, value driven on S_ACP_RDATA for error beats.

Ports:
- bus_clk  in  1  sole clock
- bus_rst  in  1  synchronous, active-high reset
- S_ACP_AWADDR  in  32  write burst start address
- S_ACP_AWLEN  in  4  beats minus 1
- S_ACP_AWSIZE  in  3  beat size
- S_ACP_AWBURST  in  2  burst type
- S_ACP_AWCACHE  in  4  ignored
- S_ACP_AWPROT  in  3  ignored
- S_ACP_AWVALID  in  1  / S_ACP_AWREADY  out  1
- S_ACP_WDATA  in  64  / S_ACP_WSTRB  in  8  / S_ACP_WLAST  in  1  / S_ACP_WVALID  in  1  / S_ACP_WREADY  out  1
- S_ACP_BRESP  out  2  / S_ACP_BVALID  out  1  / S_ACP_BREADY  in  1
- S_ACP_ARADDR  in  32  / S_ACP_ARLEN  in  4  / S_ACP_ARSIZE  in  3  / S_ACP_ARBURST  in  2
- S_ACP_ARCACHE  in  4  ignored  / S_ACP_ARPROT  in  3  ignored
- S_ACP_ARVALID  in  1  / S_ACP_ARREADY  out  1
- S_ACP_RDATA  out  64  / S_ACP_RRESP  out  2  / S_ACP_RLAST  out  1  / S_ACP_RVALID  out  1  / S_ACP_RREADY  in  1

Behaviour:
- Reset values: AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST = 0; BRESP, RRESP = 2'b00; RDATA=0. RAM contents are not cleared.
- Reset mid-burst: both FSMs return to IDLE on the next edge; the partial burst is abandoned; RAM writes already made stay.
- Word index = addr[DEPTH_LOG2+2:3]. Upper bits and addr[2:0] are ignored. The index wraps modulo depth.
- Burst legality: a burst is legal only if SIZE==3'd3 and BURST is 2'b01 (INCR) or 2'b00 (FIXED).
- Illegal bursts: SIZE!=3 or BURST==2'b10/2'b11 give SLVERR (2'b10). Writes are discarded; reads return RD_FILL.
- INCR advances the index by 1 per beat. FIXED keeps the same index for every beat.
- Write FSM, W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch index, len, burst and legality; go to W_DATA with AWREADY=0 and WREADY=1.
- Write FSM, W_DATA: each WVALID&WREADY beat writes bytes where WSTRB[i]=1 (only if the burst is legal) and increments the beat counter.
  - The burst ends on beat len+1, regardless of WLAST.
  - Any beat where WLAST != (beat==len) sets the sticky error flag.
  - After the last beat: WREADY=0, go to W_RESP.
- Write FSM, W_RESP: BVALID=1. BRESP=SLVERR if the burst is illegal or the error flag is set, else OKAY. Hold until BREADY, then go to W_IDLE with AWREADY=1 on the next cycle.
- Read FSM, R_IDLE: ARREADY=1. On handshake, latch the request and go to R_FETCH with ARREADY=0.
- Read FSM, R_FETCH: issue the synchronous RAM read (one-cycle latency), then go to R_DATA.
- Read FSM, R_DATA: RVALID=1 with RDATA/RRESP/RLAST held stable until RREADY.
  - RLAST=1 on beat len only.
  - On handshake: the last beat goes to R_IDLE; otherwise advance the index per burst type and go to R_FETCH.
- Throughput is one read beat per 2 cycles minimum. ARVALID to first RVALID takes 2 cycles.
- Same-cycle read and write to the same word: read-first (the read returns the old data).
- AR and AW handshakes in the same cycle are both accepted.

Test Plan:
- Aligned INCR write: AW addr 0x100, len 3, size 3; data 0x11..11 through 0x44..44, WSTRB 0xFF, WLAST on beat 3 -> BRESP=00. Read of the same burst returns the 4 words in order, RLAST only on beat 3.
- Byte strobes: write word 0x0 with 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with data 0 and WSTRB 0x0F -> readback 0xFFFF_FFFF_0000_0000.
- Backpressure and early WLAST:
  - RREADY toggles 1/0 during a 16-beat read -> no beat lost or duplicated; RDATA stays stable while RVALID && !RREADY.
  - Write with len 3 and WLAST on beat 1 -> 4 beats accepted, BRESP=10.
- Illegal bursts and wrap: AWBURST=10 -> BRESP=10 and RAM unchanged. ARSIZE=2 with len 1 -> 2 beats of RD_FILL, RRESP=10. INCR from the last index (0xFF8 at DEPTH_LOG2=9) wraps to index 0.
- Reset mid-burst: assert bus_rst during beat 2 of an 8-beat write -> next cycle AWREADY=1, ARREADY=1, WREADY=0, BVALID=0. Words 0-1 are written, words 2-7 are unchanged.
